// File: rtl/td4_pkg.sv
// Shared types for the TD4 core: ISA widths, opcode encoding and decoded control word.
package td4_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned PC_W   = 4;
   localparam int unsigned INSN_W = 8;

   typedef enum logic [3:0] {
      OP_ADD_A    = 4'b0000,
      OP_MOV_A_B  = 4'b0001,
      OP_IN_A     = 4'b0010,
      OP_MOV_A_IM = 4'b0011,
      OP_MOV_B_A  = 4'b0100,
      OP_ADD_B    = 4'b0101,
      OP_IN_B     = 4'b0110,
      OP_MOV_B_IM = 4'b0111,
      OP_OUT_B    = 4'b1001,
      OP_OUT_IM   = 4'b1011,
      OP_JNC      = 4'b1110,
      OP_JMP      = 4'b1111
   } opcode_t;

   typedef enum logic [1:0] {SRC_ZERO, SRC_A, SRC_B, SRC_IN} src_sel_t;
   typedef enum logic [1:0] {DST_NONE, DST_A, DST_B, DST_OUT} dst_sel_t;

   // use_imm gates the immediate into the adder; register moves ignore it.
   typedef struct packed {
      src_sel_t src_sel;
      dst_sel_t dst_sel;
      logic     use_imm;
      logic     load_pc;
      logic     use_carry;
   } decode_t;

endpackage

// File: rtl/td4_if.sv
// ROM fetch and board I/O bundle between the TD4 core and its surroundings.
interface td4_if;
   import td4_pkg::*;

   logic [PC_W-1:0]   rom_addr_out;
   logic [INSN_W-1:0] rom_data_in;
   logic [DATA_W-1:0] in_port_in;
   logic [DATA_W-1:0] out_port_out;
   logic [DATA_W-1:0] reg_a_out;
   logic [DATA_W-1:0] reg_b_out;
   logic              carry_out;

   modport master (
      output rom_addr_out, out_port_out, reg_a_out, reg_b_out, carry_out,
      input  rom_data_in, in_port_in
   );

   modport slave (
      input  rom_addr_out, out_port_out, reg_a_out, reg_b_out, carry_out,
      output rom_data_in, in_port_in
   );
endinterface

// File: rtl/td4_decoder.sv
// Combinational opcode decode; undefined opcodes fall through to a NOP control word.
module td4_decoder
   import td4_pkg::*;
(
   input  logic [3:0] opcode,
   output decode_t    dec
);

   always_comb begin
      dec = '{src_sel: SRC_ZERO, dst_sel: DST_NONE, use_imm: 1'b0,
              load_pc: 1'b0, use_carry: 1'b0};
      case (opcode)
         OP_ADD_A:    begin dec.src_sel = SRC_A;  dec.dst_sel = DST_A;   dec.use_imm = 1'b1; end
         OP_MOV_A_B:  begin dec.src_sel = SRC_B;  dec.dst_sel = DST_A;   end
         OP_IN_A:     begin dec.src_sel = SRC_IN; dec.dst_sel = DST_A;   end
         OP_MOV_A_IM: begin dec.dst_sel = DST_A;  dec.use_imm = 1'b1;    end
         OP_MOV_B_A:  begin dec.src_sel = SRC_A;  dec.dst_sel = DST_B;   end
         OP_ADD_B:    begin dec.src_sel = SRC_B;  dec.dst_sel = DST_B;   dec.use_imm = 1'b1; end
         OP_IN_B:     begin dec.src_sel = SRC_IN; dec.dst_sel = DST_B;   end
         OP_MOV_B_IM: begin dec.dst_sel = DST_B;  dec.use_imm = 1'b1;    end
         OP_OUT_B:    begin dec.src_sel = SRC_B;  dec.dst_sel = DST_OUT; end
         OP_OUT_IM:   begin dec.dst_sel = DST_OUT; dec.use_imm = 1'b1;   end
         OP_JNC:      begin dec.use_imm = 1'b1; dec.load_pc = 1'b1; dec.use_carry = 1'b1; end
         OP_JMP:      begin dec.use_imm = 1'b1; dec.load_pc = 1'b1; end
         default:     ;
      endcase
   end

endmodule

// File: rtl/td4_core.sv
// Single-cycle TD4 CPU: fetch ROM[PC], execute through one 4-bit adder, commit on the next edge.
module td4_core
   import td4_pkg::*;
(
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic en_in,
   td4_if.master bus
);

   logic [PC_W-1:0]   pc;
   logic [DATA_W-1:0] reg_a;
   logic [DATA_W-1:0] reg_b;
   logic [DATA_W-1:0] out_q;
   logic              carry;

   decode_t           dec;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] opnd;
   logic [DATA_W:0]   sum;
   logic              take_jump;
   logic [PC_W-1:0]   pc_next;

   assign imm = bus.rom_data_in[DATA_W-1:0];

   td4_decoder u_decoder (
      .opcode (bus.rom_data_in[INSN_W-1:DATA_W]),
      .dec    (dec)
   );

   // Every instruction routes through the adder, so carry is simply its MSB.
   always_comb begin
      src = '0;
      case (dec.src_sel)
         SRC_A:   src = reg_a;
         SRC_B:   src = reg_b;
         SRC_IN:  src = bus.in_port_in;
         default: src = '0;
      endcase
      opnd      = dec.use_imm ? imm : '0;
      sum       = {1'b0, src} + {1'b0, opnd};
      take_jump = dec.load_pc & ~(dec.use_carry & carry);
      pc_next   = take_jump ? sum[PC_W-1:0] : pc + PC_W'(1);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         pc    <= '0;
         reg_a <= '0;
         reg_b <= '0;
         out_q <= '0;
         carry <= 1'b0;
      end else if (en_in) begin
         pc    <= pc_next;
         carry <= sum[DATA_W];
         case (dec.dst_sel)
            DST_A:   reg_a <= sum[DATA_W-1:0];
            DST_B:   reg_b <= sum[DATA_W-1:0];
            DST_OUT: out_q <= sum[DATA_W-1:0];
            default: ;
         endcase
      end
   end

   assign bus.rom_addr_out = pc;
   assign bus.out_port_out = out_q;
   assign bus.reg_a_out    = reg_a;
   assign bus.reg_b_out    = reg_b;
   assign bus.carry_out    = carry;

endmodule

// File: tb/tb_td4_core.sv
// Directed bench for td4_core: an instruction-level reference model checked every cycle,
// plus hand-computed expectations at key points of each program.
module tb_td4_core;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic       en_in;
   logic [3:0] in_port;
   logic [7:0] rom [16];

   int checks = 0;
   int passed = 0;

   td4_if bus ();

   assign bus.rom_data_in = rom[bus.rom_addr_out];
   assign bus.in_port_in  = in_port;

   td4_core dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .en_in    (en_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: executes one instruction per enabled edge from the ISA table.
   int  m_pc, m_a, m_b, m_c, m_out;
   bit  m_valid = 1'b0;

   always @(posedge clk_in) begin
      int op, im, t, npc, nc;
      if (!rst_n_in) begin
         m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
         m_valid = 1'b1;
      end else if (en_in && m_valid) begin
         op  = int'(rom[m_pc][7:4]);
         im  = int'(rom[m_pc][3:0]);
         npc = (m_pc + 1) % 16;
         nc  = 0;
         case (op)
            0:  begin t = m_a + im; m_a = t % 16; nc = (t > 15) ? 1 : 0; end
            5:  begin t = m_b + im; m_b = t % 16; nc = (t > 15) ? 1 : 0; end
            3:  m_a = im;
            7:  m_b = im;
            1:  m_a = m_b;
            4:  m_b = m_a;
            2:  m_a = int'(in_port);
            6:  m_b = int'(in_port);
            9:  m_out = m_b;
            11: m_out = im;
            15: npc = im;
            14: if (m_c == 0) npc = im;
            default: ;
         endcase
         m_c  = nc;
         m_pc = npc;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk_in) begin
      if (m_valid) begin
         chk("model_pc",  int'(bus.rom_addr_out), m_pc);
         chk("model_a",   int'(bus.reg_a_out),    m_a);
         chk("model_b",   int'(bus.reg_b_out),    m_b);
         chk("model_c",   int'(bus.carry_out),    m_c);
         chk("model_out", int'(bus.out_port_out), m_out);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic fill_rom(input logic [7:0] v);
      for (int i = 0; i < 16; i++) rom[i] = v;
   endtask

   // Two reset edges, then release on a negedge so the program starts cleanly.
   task automatic do_reset();
      @(negedge clk_in);
      rst_n_in = 1'b0;
      step(2);
      rst_n_in = 1'b1;
   endtask

   initial begin
      rst_n_in = 1'b0;
      en_in    = 1'b1;
      in_port  = 4'h0;
      fill_rom(8'h30);

      // 1: reset after arbitrary activity
      do_reset();
      rom[0] = 8'h3C; rom[1] = 8'h75; rom[2] = 8'hB9; rom[3] = 8'h0F;
      step(4);
      do_reset();
      chk("rst_pc",  int'(bus.rom_addr_out), 0);
      chk("rst_a",   int'(bus.reg_a_out),    0);
      chk("rst_b",   int'(bus.reg_b_out),    0);
      chk("rst_c",   int'(bus.carry_out),    0);
      chk("rst_out", int'(bus.out_port_out), 0);

      // 2/3: carry out of ADD, then JNC not taken / taken
      fill_rom(8'h30);
      rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE5; rom[3] = 8'hE8;
      do_reset();
      step(2);
      chk("add_wrap_a",  int'(bus.reg_a_out),    0);
      chk("add_carry",   int'(bus.carry_out),    1);
      chk("add_pc",      int'(bus.rom_addr_out), 2);
      step(1);
      chk("jnc_nt_pc",   int'(bus.rom_addr_out), 3);
      chk("jnc_nt_c",    int'(bus.carry_out),    0);
      step(1);
      chk("jnc_t_pc",    int'(bus.rom_addr_out), 8);

      // 4: IN / MOV / OUT
      fill_rom(8'h30);
      rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h90; rom[3] = 8'hB7;
      in_port = 4'hA;
      do_reset();
      step(3);
      chk("out_b",   int'(bus.out_port_out), 10);
      in_port = 4'h3;
      step(1);
      chk("out_im",  int'(bus.out_port_out), 7);
      chk("mov_b_a", int'(bus.reg_b_out),    10);

      // 5: PC wrap, then undefined opcodes act as NOP and clear carry
      fill_rom(8'h30);
      do_reset();
      step(16);
      chk("pc_wrap", int'(bus.rom_addr_out), 0);
      rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'h85;
      rom[3] = 8'h7E; rom[4] = 8'h53; rom[5] = 8'hA2;
      rom[6] = 8'h57; rom[7] = 8'hC1; rom[8] = 8'h5F; rom[9] = 8'hD4;
      rom[10] = 8'hF0;
      do_reset();
      step(3);
      chk("nop8_pc", int'(bus.rom_addr_out), 3);
      chk("nop8_c",  int'(bus.carry_out),    0);
      chk("nop8_a",  int'(bus.reg_a_out),    0);
      step(2);
      chk("addb_wrap_b", int'(bus.reg_b_out), 1);
      chk("addb_carry",  int'(bus.carry_out), 1);
      step(6);
      chk("jmp_pc", int'(bus.rom_addr_out), 0);
      chk("jmp_c",  int'(bus.carry_out),    0);
      chk("nop_b",  int'(bus.reg_b_out),    7);

      // 6: enable hold, then reset wins over en_in=0
      fill_rom(8'h30);
      rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hB6; rom[3] = 8'h79;
      do_reset();
      step(3);
      en_in = 1'b0;
      step(5);
      chk("hold_pc",  int'(bus.rom_addr_out), 3);
      chk("hold_a",   int'(bus.reg_a_out),    0);
      chk("hold_out", int'(bus.out_port_out), 6);
      rst_n_in = 1'b0;
      step(1);
      chk("rst_pri_pc",  int'(bus.rom_addr_out), 0);
      chk("rst_pri_out", int'(bus.out_port_out), 0);
      rst_n_in = 1'b1;
      en_in    = 1'b1;
      step(4);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
